seq_divider: RTL and testbench
==============================

SEQ_DIVIDER -- requirements
Module: seq_divider

Interface
REQ-001 SHALL have parameter WIDTH, default 32, meaning operand width in bits (legal 8..64).
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port resetn  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port start_i  input  1  request a divide; held high by the requester until ready_o is seen.
REQ-005 SHALL have port signed_i  input  1  1 = two's-complement divide, 0 = unsigned.
REQ-006 SHALL have port opdata1_i  input  WIDTH  dividend.
REQ-007 SHALL have port opdata2_i  input  WIDTH  divisor.
REQ-008 SHALL have port annul_i  input  1  abort any operation in flight.
REQ-009 SHALL have port result_o  output  2*WIDTH  {remainder, quotient}; remainder occupies the upper half.
REQ-010 SHALL have port ready_o  output  1  result_o valid.
REQ-011 SHALL have port busy_o  output  1  state is not IDLE and not END; drives the requester's stall request.

Function
REQ-012 SHALL implement states IDLE, DIVZERO, ON and END.
REQ-013 In IDLE with start_i=1 and annul_i=0, SHALL latch opdata1_i, opdata2_i and signed_i, then go to DIVZERO if the divisor is 0, otherwise to ON; later input changes SHALL be ignored until the next start.
REQ-014 ON SHALL perform one restoring radix-2 step per cycle on operand magnitudes, WIDTH steps total, using a (2*WIDTH+1)-bit partial-remainder register and a log2(WIDTH)+1-bit step counter, then go to END.
REQ-015 ready_o SHALL rise exactly WIDTH+1 cycles after the start-sampling edge for a nonzero divisor, and 2 cycles after it for a zero divisor.
REQ-016 DIVZERO SHALL set quotient to all ones and remainder to the dividend, then go to END after 1 cycle.
REQ-017 In signed mode, the quotient SHALL be negated when the operand signs differ, and the remainder SHALL take the sign of the dividend.
REQ-018 Signed most-negative / -1 SHALL give quotient = most-negative and remainder = 0, with no flag.
REQ-019 END SHALL hold ready_o=1 and keep result_o stable while start_i=1, and SHALL return to IDLE on the first cycle with start_i=0.
REQ-020 result_o SHALL keep its last value in IDLE until the next completion.
REQ-021 annul_i=1 in any state SHALL force IDLE on the next edge with ready_o=0 and result_o unchanged; annul_i SHALL take priority over start_i in the same cycle.
REQ-022 Back-to-back operation SHALL be possible: at minimum one IDLE cycle separates END from the next accepted start.

Reset
REQ-023 resetn=0 SHALL immediately force IDLE, ready_o=0, busy_o=0, result_o=0 and step counter 0, including mid-operation.
REQ-024 Release of resetn SHALL be synchronised by the integrating top level; the block SHALL accept a start on the first edge after release.

Configuration
REQ-025 Macro SEQ_DIVIDER_EARLY_OUT_EN: when defined, SHALL skip ON whenever |dividend| < |divisor| (divisor nonzero), going from IDLE through a single ON cycle to END with quotient 0 and remainder = dividend, so ready_o rises 2 cycles after start.
REQ-026 Without SEQ_DIVIDER_EARLY_OUT_EN, every nonzero-divisor operation SHALL take the full WIDTH+1 cycles, and no comparator logic SHALL be synthesised.

Structure
REQ-027 Shared package div_pkg SHALL hold the state enum (IDLE/DIVZERO/ON/END), the DivStart/DivStop and DivResultReady/DivResultNotReady constants, and the result field-position constants.
REQ-028 Sub-module div_abs_neg SHALL be used for conditional two's-complement conversion, instantiated for operand magnitude on the input side and result sign fix-up on the output side; datapath and FSM SHALL stay in seq_divider.

Verification (WIDTH=32)
REQ-029 Unsigned 100 / 7 -> ready_o rises at cycle 33 with quotient 14 and remainder 2; busy_o is high for cycles 1..32.
REQ-030 Signed -7 / 2 -> quotient 0xFFFFFFFD and remainder 0xFFFFFFFF.
REQ-031 Divisor 0, dividend 0x12345678 -> ready_o rises at cycle 2 with quotient 0xFFFFFFFF and remainder 0x12345678.
REQ-032 Signed 0x80000000 / 0xFFFFFFFF -> quotient 0x80000000 and remainder 0.
REQ-033 annul_i pulsed at cycle 10 of a divide -> IDLE at cycle 11, ready_o never rises, and a new start at cycle 12 completes correctly.
REQ-034 resetn pulled low at cycle 5 -> outputs are 0 asynchronously; with SEQ_DIVIDER_EARLY_OUT_EN defined, unsigned 3 / 10 -> ready_o rises at cycle 2 with quotient 0 and remainder 3.

Source files
------------

// File: rtl/div_pkg.sv
// Shared types and constants for the sequential divider: FSM states,
// start/ready encodings and the {remainder, quotient} field positions.
package div_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    DIVZERO = 2'd1,
    ON      = 2'd2,
    END     = 2'd3
  } div_state_e;

  localparam logic DivStart          = 1'b1;
  localparam logic DivStop           = 1'b0;
  localparam logic DivResultReady    = 1'b1;
  localparam logic DivResultNotReady = 1'b0;

  // Quotient sits in the low half of the result, remainder in the high half.
  localparam int unsigned QUOT_LSB = 0;

  function automatic int unsigned quot_msb(input int unsigned width);
    return width - 1;
  endfunction

  function automatic int unsigned rem_lsb(input int unsigned width);
    return width;
  endfunction

  function automatic int unsigned rem_msb(input int unsigned width);
    return 2 * width - 1;
  endfunction

endpackage

// File: rtl/div_abs_neg.sv
// Conditional two's-complement: passes data through, or negates it when neg_i
// is set. Used for operand magnitudes and for result sign fix-up.
module div_abs_neg #(
  parameter int WIDTH = 32
) (
  input  logic             neg_i,
  input  logic [WIDTH-1:0] data_i,
  output logic [WIDTH-1:0] data_o
);

  assign data_o = neg_i ? (~data_i + {{(WIDTH-1){1'b0}}, 1'b1}) : data_i;

endmodule

// File: rtl/seq_divider.sv
// Restoring radix-2 sequential divider, signed or unsigned, one quotient bit
// per cycle. Optional macro SEQ_DIVIDER_EARLY_OUT_EN skips work when |a| < |b|.
module seq_divider
  import div_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               start_i,
  input  logic               signed_i,
  input  logic [WIDTH-1:0]   opdata1_i,
  input  logic [WIDTH-1:0]   opdata2_i,
  input  logic               annul_i,
  output logic [2*WIDTH-1:0] result_o,
  output logic               ready_o,
  output logic               busy_o
);

  localparam int CNT_W   = $clog2(WIDTH) + 1;
  localparam int REM_W   = 2 * WIDTH + 1;
  localparam int Q_MSB   = quot_msb(WIDTH);
  localparam int R_LSB   = rem_lsb(WIDTH);
  localparam int R_MSB   = rem_msb(WIDTH);

  div_state_e         state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [REM_W-1:0]   rem_q, rem_d;
  logic [WIDTH-1:0]   div_q, div_d;
  logic [WIDTH-1:0]   op1_q, op1_d;
  logic               quot_neg_q, quot_neg_d;
  logic               rem_neg_q, rem_neg_d;
  logic               early_q, early_d;
  logic [2*WIDTH-1:0] result_q, result_d;
  logic               ready_q, ready_d;
  logic               busy_q, busy_d;

  logic               a_neg_s, b_neg_s, early_s;
  logic [WIDTH-1:0]   a_mag_s, b_mag_s;
  logic [REM_W-1:0]   shifted_s, step_s;
  logic [WIDTH:0]     diff_s;
  logic [WIDTH-1:0]   quot_fix_s, rem_fix_s;

  assign a_neg_s = signed_i & opdata1_i[WIDTH-1];
  assign b_neg_s = signed_i & opdata2_i[WIDTH-1];

  div_abs_neg #(.WIDTH(WIDTH)) u_abs_a (.neg_i(a_neg_s), .data_i(opdata1_i), .data_o(a_mag_s));
  div_abs_neg #(.WIDTH(WIDTH)) u_abs_b (.neg_i(b_neg_s), .data_i(opdata2_i), .data_o(b_mag_s));

`ifdef SEQ_DIVIDER_EARLY_OUT_EN
  assign early_s = (a_mag_s < b_mag_s);
`else
  assign early_s = 1'b0;
`endif

  // A set top bit would mean the partial remainder already exceeds the divisor.
  assign shifted_s = {rem_q[REM_W-2:0], 1'b0};
  assign diff_s    = shifted_s[REM_W-1:WIDTH] - {1'b0, div_q};
  assign step_s    = (rem_q[REM_W-1] | ~diff_s[WIDTH]) ?
                     {diff_s, shifted_s[WIDTH-1:1], 1'b1} : shifted_s;

  div_abs_neg #(.WIDTH(WIDTH)) u_fix_q (
    .neg_i(quot_neg_q), .data_i(step_s[Q_MSB:QUOT_LSB]), .data_o(quot_fix_s));
  div_abs_neg #(.WIDTH(WIDTH)) u_fix_r (
    .neg_i(rem_neg_q), .data_i(step_s[R_MSB:R_LSB]), .data_o(rem_fix_s));

  // Next-state, datapath and output decode.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    rem_d      = rem_q;
    div_d      = div_q;
    op1_d      = op1_q;
    quot_neg_d = quot_neg_q;
    rem_neg_d  = rem_neg_q;
    early_d    = early_q;
    result_d   = result_q;
    ready_d    = DivResultNotReady;
    if (annul_i) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start_i == DivStart) begin
            op1_d      = opdata1_i;
            div_d      = b_mag_s;
            rem_d      = {{(WIDTH+1){1'b0}}, a_mag_s};
            quot_neg_d = a_neg_s ^ b_neg_s;
            rem_neg_d  = a_neg_s;
            early_d    = early_s;
            cnt_d      = '0;
            if (opdata2_i == '0) begin
              state_d = DIVZERO;
            end else begin
              state_d = ON;
            end
          end else begin
            state_d = IDLE;
          end
        end
        DIVZERO: begin
          result_d[Q_MSB:QUOT_LSB] = '1;
          result_d[R_MSB:R_LSB]    = op1_q;
          ready_d                  = DivResultReady;
          state_d                  = END;
        end
        ON: begin
          if (early_q) begin
            result_d[Q_MSB:QUOT_LSB] = '0;
            result_d[R_MSB:R_LSB]    = op1_q;
            ready_d                  = DivResultReady;
            state_d                  = END;
          end else begin
            rem_d = step_s;
            cnt_d = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_W'(WIDTH - 1)) begin
              result_d[Q_MSB:QUOT_LSB] = quot_fix_s;
              result_d[R_MSB:R_LSB]    = rem_fix_s;
              ready_d                  = DivResultReady;
              state_d                  = END;
            end else begin
              state_d = ON;
            end
          end
        end
        END: begin
          if (start_i == DivStop) begin
            state_d = IDLE;
          end else begin
            ready_d = DivResultReady;
            state_d = END;
          end
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
    busy_d = (state_d == ON) || (state_d == DIVZERO);
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      rem_q      <= '0;
      div_q      <= '0;
      op1_q      <= '0;
      quot_neg_q <= 1'b0;
      rem_neg_q  <= 1'b0;
      early_q    <= 1'b0;
      result_q   <= '0;
      ready_q    <= DivResultNotReady;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      rem_q      <= rem_d;
      div_q      <= div_d;
      op1_q      <= op1_d;
      quot_neg_q <= quot_neg_d;
      rem_neg_q  <= rem_neg_d;
      early_q    <= early_d;
      result_q   <= result_d;
      ready_q    <= ready_d;
      busy_q     <= busy_d;
    end
  end

  assign result_o = result_q;
  assign ready_o  = ready_q;
  assign busy_o   = busy_q;

endmodule

// File: tb/tb_seq_divider.sv
// Directed self-checking bench for seq_divider at WIDTH=32; honours
// SEQ_DIVIDER_EARLY_OUT_EN for the |a| < |b| latency expectation.
module tb_seq_divider;

  localparam int W = 32;

`ifdef SEQ_DIVIDER_EARLY_OUT_EN
  localparam int EO_CYC  = 2;
  localparam int EO_BUSY = 1;
`else
  localparam int EO_CYC  = 33;
  localparam int EO_BUSY = 32;
`endif

  logic           clk = 1'b0;
  logic           resetn = 1'b0;
  logic           start_i = 1'b0;
  logic           signed_i = 1'b0;
  logic [W-1:0]   opdata1_i = '0;
  logic [W-1:0]   opdata2_i = '0;
  logic           annul_i = 1'b0;
  logic [2*W-1:0] result_o;
  logic           ready_o;
  logic           busy_o;

  int checks = 0;
  int errors = 0;

  seq_divider #(.WIDTH(W)) dut (
    .clk(clk), .resetn(resetn), .start_i(start_i), .signed_i(signed_i),
    .opdata1_i(opdata1_i), .opdata2_i(opdata2_i), .annul_i(annul_i),
    .result_o(result_o), .ready_o(ready_o), .busy_o(busy_o)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One full handshake; cycle 1 is the cycle after the start-sampling edge.
  task automatic run_div(input string tag, input logic sgn, input logic [W-1:0] a,
                         input logic [W-1:0] b, input logic [63:0] exp_res,
                         input int exp_cyc, input int exp_busy);
    int cyc;
    int busy_cnt;
    cyc = 0;
    busy_cnt = 0;
    @(negedge clk);
    start_i = 1'b1; signed_i = sgn; opdata1_i = a; opdata2_i = b;
    @(posedge clk);
    for (int i = 1; i <= 100; i++) begin
      #1;
      if (i == 1) begin
        opdata1_i = ~a; opdata2_i = '0; signed_i = ~sgn;
      end
      if (ready_o) begin
        cyc = i;
        break;
      end
      if (busy_o) busy_cnt++;
      @(posedge clk);
    end
    check_eq({tag, " ready_cycle"}, 64'(cyc), 64'(exp_cyc));
    check_eq({tag, " busy_cycles"}, 64'(busy_cnt), 64'(exp_busy));
    check_eq({tag, " result"}, result_o, exp_res);
    @(posedge clk); #1;
    check_eq({tag, " end_hold_ready"}, 64'(ready_o), 64'd1);
    check_eq({tag, " end_hold_result"}, result_o, exp_res);
    start_i = 1'b0;
    @(posedge clk); #1;
    check_eq({tag, " idle_ready"}, 64'(ready_o), 64'd0);
    check_eq({tag, " idle_busy"}, 64'(busy_o), 64'd0);
    check_eq({tag, " idle_result"}, result_o, exp_res);
  endtask

  initial begin
    #12;
    check_eq("reset ready", 64'(ready_o), 64'd0);
    check_eq("reset busy", 64'(busy_o), 64'd0);
    check_eq("reset result", result_o, 64'd0);
    @(posedge clk); #2;
    resetn = 1'b1;

    run_div("u100_7",   1'b0, 32'd100,        32'd7,          {32'd2, 32'd14},                 33, 32);
    run_div("s-7_2",    1'b1, 32'hFFFFFFF9,   32'd2,          {32'hFFFFFFFF, 32'hFFFFFFFD},    33, 32);
    run_div("s7_-2",    1'b1, 32'd7,          32'hFFFFFFFE,   {32'd1, 32'hFFFFFFFD},           33, 32);
    run_div("s-100_-7", 1'b1, 32'hFFFFFF9C,   32'hFFFFFFF9,   {32'hFFFFFFFE, 32'd14},          33, 32);
    run_div("uffff_16", 1'b0, 32'hFFFFFFFF,   32'h10,         {32'hF, 32'h0FFFFFFF},           33, 32);
    run_div("div0",     1'b0, 32'h12345678,   32'd0,          {32'h12345678, 32'hFFFFFFFF},    2,  1);
    run_div("sdiv0",    1'b1, 32'hFFFFFFFB,   32'd0,          {32'hFFFFFFFB, 32'hFFFFFFFF},    2,  1);
    run_div("u3_10",    1'b0, 32'd3,          32'd10,         {32'd3, 32'd0},                  EO_CYC, EO_BUSY);
    run_div("mostneg",  1'b1, 32'h80000000,   32'hFFFFFFFF,   {32'd0, 32'h80000000},           33, 32);

    // Abort mid-divide: annul raised during cycle 10, IDLE by cycle 11.
    @(negedge clk);
    start_i = 1'b1; signed_i = 1'b0; opdata1_i = 32'd100; opdata2_i = 32'd7;
    @(posedge clk);
    repeat (9) @(posedge clk);
    #1;
    annul_i = 1'b1; start_i = 1'b0;
    check_eq("annul busy_before", 64'(busy_o), 64'd1);
    @(posedge clk); #1;
    annul_i = 1'b0;
    check_eq("annul busy", 64'(busy_o), 64'd0);
    check_eq("annul ready", 64'(ready_o), 64'd0);
    check_eq("annul result_kept", result_o, {32'd0, 32'h80000000});
    run_div("after_annul", 1'b0, 32'd1000, 32'd9, {32'd1, 32'd111}, 33, 32);

    // Asynchronous reset mid-operation.
    @(negedge clk);
    start_i = 1'b1; signed_i = 1'b0; opdata1_i = 32'hFFFFFFFF; opdata2_i = 32'h10;
    @(posedge clk);
    repeat (4) @(posedge clk);
    #2;
    resetn = 1'b0; start_i = 1'b0;
    #1;
    check_eq("rst ready", 64'(ready_o), 64'd0);
    check_eq("rst busy", 64'(busy_o), 64'd0);
    check_eq("rst result", result_o, 64'd0);
    @(posedge clk); #2;
    resetn = 1'b1;
    run_div("after_rst", 1'b0, 32'd100, 32'd7, {32'd2, 32'd14}, 33, 32);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
